// File: rtl/mux_arb_pkg.sv
//==============================================================================
// Module   : mux_arb_pkg
// Brief    : Shared defaults, FSM state type and grant-encoding helper for
//            the round-robin mux port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NUM_PORTS = 10;
    localparam int SEL_WIDTH = 4;
    localparam int MAX_BURST = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [SEL_WIDTH-1:0] onehot_to_bin(input logic [NUM_PORTS-1:0] oh);
        logic [SEL_WIDTH-1:0] bin;
        bin = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) begin
                bin = bin | SEL_WIDTH'(i);
            end
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_port_arbiter_if.sv
//==============================================================================
// Module   : mux_port_arbiter_if
// Brief    : Request/grant bundle between requesters and the mux arbiter.
//            MUX_ARB_URGENT_PORT_EN adds the urgent input for port 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mux_port_arbiter_if #(
    parameter int NUM_PORTS = mux_arb_pkg::NUM_PORTS,
    parameter int SEL_WIDTH = mux_arb_pkg::SEL_WIDTH
);
    import mux_arb_pkg::*;

    logic                 en;
    logic [NUM_PORTS-1:0] req;
`ifdef MUX_ARB_URGENT_PORT_EN
    logic                 urgent;
`endif
    logic [NUM_PORTS-1:0] gnt;
    logic [SEL_WIDTH-1:0] sel;
    logic                 sel_valid;
    logic                 switch_pulse;

`ifdef MUX_ARB_URGENT_PORT_EN
    modport master (output en, req, urgent, input gnt, sel, sel_valid, switch_pulse);
    modport slave  (input en, req, urgent, output gnt, sel, sel_valid, switch_pulse);
`else
    modport master (output en, req, input gnt, sel, sel_valid, switch_pulse);
    modport slave  (input en, req, output gnt, sel, sel_valid, switch_pulse);
`endif

endinterface

`default_nettype wire

// File: rtl/mux_port_arbiter_rr_pick.sv
//==============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first set request strictly
//            after last_ptr, wrapping to port 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_PORTS = mux_arb_pkg::NUM_PORTS,
    parameter int SEL_WIDTH = mux_arb_pkg::SEL_WIDTH
) (
    input  wire logic [NUM_PORTS-1:0] req,
    input  wire logic [SEL_WIDTH-1:0] last_ptr,
    output logic      [SEL_WIDTH-1:0] winner,
    output logic                      any_req
);

    logic w_found;

    // Two passes: ports above the pointer first, then the wrapped-around ones.
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && req[i] && (SEL_WIDTH'(i) > last_ptr)) begin
                winner  = SEL_WIDTH'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && req[i]) begin
                winner  = SEL_WIDTH'(i);
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/mux_port_arbiter.sv
//==============================================================================
// Module   : mux_port_arbiter
// Brief    : Round-robin burst scheduler driving the output mux select and a
//            one-hot grant. MUX_ARB_URGENT_PORT_EN enables port-0 pre-emption.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_port_arbiter #(
    parameter int NUM_PORTS = mux_arb_pkg::NUM_PORTS,
    parameter int SEL_WIDTH = mux_arb_pkg::SEL_WIDTH,
    parameter int MAX_BURST = mux_arb_pkg::MAX_BURST
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_port_arbiter_if.slave bus
);
    import mux_arb_pkg::*;

    localparam int c_cnt_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(MAX_BURST - 1);

    arb_state_e           r_state,    w_state_nxt;
    logic [NUM_PORTS-1:0] r_gnt,      w_gnt_nxt;
    logic [SEL_WIDTH-1:0] r_sel,      w_sel_nxt;
    logic [SEL_WIDTH-1:0] r_last_ptr, w_last_nxt;
    logic [c_cnt_w-1:0]   r_beat,     w_beat_nxt;
    logic                 r_pulse,    w_pulse_nxt;
    logic                 r_sel_valid;
    logic [SEL_WIDTH-1:0] w_winner;
    logic                 w_any_req;
    logic                 w_hold;
    logic                 w_arb;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_pick (
        .req      (bus.req),
        .last_ptr (r_last_ptr),
        .winner   (w_winner),
        .any_req  (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_last_ptr  <= SEL_WIDTH'(NUM_PORTS - 1);
            r_beat      <= '0;
            r_pulse     <= 1'b0;
            r_sel_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_last_ptr  <= w_last_nxt;
            r_beat      <= w_beat_nxt;
            r_pulse     <= w_pulse_nxt;
            r_sel_valid <= |w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last_ptr;
        w_beat_nxt  = r_beat;
        w_pulse_nxt = 1'b0;
        w_arb       = 1'b0;
        w_hold      = bus.req[r_sel] && (r_beat != c_last_beat);

        case (r_state)
            IDLE: w_arb = bus.en && w_any_req;
            BUSY: begin
                if (w_hold) begin
                    w_beat_nxt = r_beat + c_cnt_w'(1);
                end else if (bus.en && w_any_req) begin
                    w_arb = 1'b1;
                end else begin
                    // sel deliberately keeps its last value while idle
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        if (w_arb) begin
            w_gnt_nxt   = NUM_PORTS'(1) << w_winner;
            w_sel_nxt   = onehot_to_bin(w_gnt_nxt);
            w_last_nxt  = w_winner;
            w_beat_nxt  = '0;
            w_pulse_nxt = 1'b1;
            w_state_nxt = BUSY;
        end

`ifdef MUX_ARB_URGENT_PORT_EN
        // Urgent grants leave last_ptr alone so the rotation resumes in place.
        if (bus.urgent && bus.req[0] && bus.en &&
            (w_arb || ((r_state == BUSY) && (r_sel != '0)))) begin
            w_gnt_nxt   = NUM_PORTS'(1);
            w_sel_nxt   = '0;
            w_last_nxt  = r_last_ptr;
            w_beat_nxt  = '0;
            w_pulse_nxt = 1'b1;
            w_state_nxt = BUSY;
        end
`endif
    end

    assign bus.gnt          = r_gnt;
    assign bus.sel          = r_sel;
    assign bus.sel_valid    = r_sel_valid;
    assign bus.switch_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_mux_port_arbiter.sv
//==============================================================================
// Module   : tb_mux_port_arbiter
// Brief    : Randomized self-checking bench for mux_port_arbiter against a
//            behavioural round-robin model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_port_arbiter;

    localparam int N  = 10;
    localparam int SW = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_port_arbiter_if #(.NUM_PORTS(N), .SEL_WIDTH(SW)) bus ();

    mux_port_arbiter #(
        .NUM_PORTS (N),
        .SEL_WIDTH (SW),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: granted port (-1 = none), last select, beats used.
    int m_gnt   = -1;
    int m_sel   = 0;
    int m_cnt   = 0;
    int m_last  = N - 1;
    bit m_pulse = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last + k) % N;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rs, input logic e, input logic [N-1:0] r);
        int w;
        if (rs) begin
            m_gnt = -1; m_sel = 0; m_cnt = 0; m_last = N - 1; m_pulse = 1'b0;
        end else if (m_gnt >= 0 && r[m_gnt] && m_cnt < MB - 1) begin
            m_cnt++;
            m_pulse = 1'b0;
        end else begin
            w = e ? rr_next(r, m_last) : -1;
            if (w >= 0) begin
                m_gnt = w; m_sel = w; m_last = w; m_cnt = 0; m_pulse = 1'b1;
            end else begin
                m_gnt = -1; m_pulse = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_gnt;
        exp_gnt = (m_gnt < 0) ? '0 : (N'(1) << m_gnt);
        check_eq("gnt",          32'(bus.gnt),          32'(exp_gnt));
        check_eq("sel",          32'(bus.sel),          32'(m_sel));
        check_eq("sel_valid",    32'(bus.sel_valid),    32'(m_gnt >= 0));
        check_eq("switch_pulse", 32'(bus.switch_pulse), 32'(m_pulse));
    endtask

    function automatic logic [N-1:0] gen_req(input int mode, input logic [N-1:0] prev);
        logic [N-1:0] r;
        case (mode)
            0:       r = N'('h004);
            1:       r = N'('h3FF);
            2:       r = N'($urandom);
            3:       r = N'($urandom) & N'($urandom) & N'($urandom);
            default: begin
                r = prev;
                if ($urandom_range(0, 2) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            end
        endcase
        return r;
    endfunction

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.req = '0;
`ifdef MUX_ARB_URGENT_PORT_EN
        bus.urgent = 1'b0;
`endif
        repeat (2) begin
            @(posedge clk);
            model_step(rst, bus.en, bus.req);
        end

        for (int phase = 0; phase < 5; phase++) begin
            for (int cyc = 0; cyc < 80; cyc++) begin
                @(negedge clk);
                check_outputs();
                rst     = (phase >= 2) && ($urandom_range(0, 63) == 0);
                bus.en  = (phase < 2) ? 1'b1 : ($urandom_range(0, 5) != 0);
                bus.req = gen_req(phase, bus.req);
                @(posedge clk);
                model_step(rst, bus.en, bus.req);
            end
        end

        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_port_arbiter.md
Name: mux_port_arbiter

Overview:
- Round-robin scheduler that shares the 10-port, 8-bit output mux between its input ports.
- Takes per-port request lines and drives the mux select plus a one-hot grant back to each requester.
- A granted port holds the mux for a bounded burst before the next requester gets it.
- Sits beside the mux inside the top level: its sel output feeds the mux sel input; sel_valid qualifies mux data.

Parameters:
- NUM_PORTS, 10, number of requesting ports (max 2**SEL_WIDTH).
- SEL_WIDTH, 4, width of the mux select.
- MAX_BURST, 4, max consecutive cycles one port may hold the grant (>=1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; low blocks new grants, current burst completes.
- req  input  NUM_PORTS  per-port request, level-sensitive.
- gnt  output  NUM_PORTS  one-hot grant, registered.
- sel  output  SEL_WIDTH  mux select, binary encoding of gnt, registered.
- sel_valid  output  1  high when gnt non-zero; mux output valid this cycle.
- switch_pulse  output  1  one-cycle pulse on any cycle where the granted port changes or is re-granted.

Behaviour:
- Reset (rst=1 at edge):
  - gnt=0, sel=0, sel_valid=0, switch_pulse=0.
  - State IDLE, beat_cnt=0, last_ptr=NUM_PORTS-1, so the first arbitration favours port 0.
- States: IDLE, BUSY.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit searching from last_ptr+1 upward, wrapping NUM_PORTS-1 -> 0.
  - Register the winner into gnt/sel and set last_ptr=winner, sel_valid=1, switch_pulse=1, beat_cnt=0, go BUSY.
  - Latency: req asserted in cycle N -> gnt in cycle N+1.
- BUSY, hold:
  - Each cycle beat_cnt increments.
  - Hold the grant while req[sel]=1 and beat_cnt < MAX_BURST-1; switch_pulse=0.
- BUSY, end of burst: occurs when req[sel]=0 or beat_cnt==MAX_BURST-1.
  - If en=1 and any req set: re-arbitrate from last_ptr+1 in the same cycle, no bubble cycle. The new grant is visible next cycle; beat_cnt=0; switch_pulse=1.
  - If the current port is the only requester, it is re-granted (same sel, switch_pulse=1).
  - If en=0 or req==0: go IDLE; gnt=0, sel_valid=0; sel holds its last value.
- en deassert mid-burst: burst continues until its normal end, then IDLE. No new grant while en=0.
- req of the granted port dropping: grant removed (or moved) at the next edge. Exactly one cycle of stale grant after the drop.
- Invariants:
  - gnt has at most one bit set.
  - sel < NUM_PORTS always.
  - sel_valid == |gnt.
- rst during BUSY: next cycle matches reset values; no partial burst resumes.
- MAX_BURST=1: grant re-evaluated every cycle; pure per-cycle round-robin.

Optional Feature:
- Macro: MUX_ARB_URGENT_PORT_EN.
- Defined:
  - Adds input urgent (1 bit).
  - When urgent=1 and req[0]=1, port 0 wins the next arbitration regardless of the pointer.
  - Port 0 also pre-empts a current burst at the next edge; switch_pulse=1.
  - last_ptr is not updated by urgent grants, so round-robin fairness resumes where it left off.
- Not defined: no urgent port; pure round-robin as above.

Decomposition:
- Package mux_arb_pkg:
  - NUM_PORTS/SEL_WIDTH/MAX_BURST defaults.
  - State enum arb_state_e {IDLE, BUSY}.
  - Function onehot_to_bin.
- One sub-module rr_pick:
  - Combinational.
  - Inputs: req, last_ptr. Outputs: winner index, any_req.
  - Instantiated once by mux_port_arbiter.

Test Plan:
- Reset then req=10'b00_0000_0100 held, en=1 -> gnt=0x004, sel=2, sel_valid=1 from the second cycle. Re-granted every 4 cycles with switch_pulse pulses.
- req=0x3FF held, MAX_BURST=4 -> sel sequence 0,1,...,9,0, each held exactly 4 cycles, no idle cycle between.
- Port 3 granted, req[3] dropped after 2 cycles while req[7]=1 -> sel becomes 7 on the following edge, switch_pulse=1 for one cycle.
- en=0 mid-burst on port 5 with req=0x3FF -> burst ends after its 4th cycle, then gnt=0, sel_valid=0, sel stays 5. en=1 again -> sel=6 next cycle.
- rst=1 while BUSY on port 8 -> next cycle gnt=0, sel=0, sel_valid=0. After release with req=0x3FF, first grant is port 0.
- With MUX_ARB_URGENT_PORT_EN: port 4 bursting, urgent=1 and req[0]=1 -> sel=0 next cycle. Afterwards round-robin resumes at port 5.
